// File: rtl/wb_host_seq_if.sv
// Command, response and Wishbone master signals of wb_host_seq grouped as one bundle.
// The master modport is the sequencer; the slave modport is the command source, response sink and bus slave.
interface wb_host_seq_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [31:0] cmd_dat_i;
  logic [3:0]  cmd_sel_i;

  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  rsp_ready_i,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_err_o,
    output rsp_ready_i,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface

// File: rtl/wb_host_seq.sv
// Single-transfer Wishbone classic initiator driven by a valid/ready command channel.
// Returns read data or a timeout error on a valid/ready response channel.
//
// state | meaning
// IDLE  | ready for a command, bus idle
// BUS   | cyc/stb asserted, waiting for ack or timeout
// RESP  | response held until consumed
module wb_host_seq #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TXN_CNT_W      = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  wb_host_seq_if.master        bus,
  output logic [TXN_CNT_W-1:0] txn_cnt_o,
  output logic [7:0]           err_cnt_o,
  output logic                 stray_ack_o
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] wait_cnt;
  logic        cyc_q;

  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      cyc_q           <= 1'b0;
      bus.cmd_ready_o <= 1'b0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_dat_o   <= '0;
      bus.rsp_err_o   <= 1'b0;
      bus.wbm_we_o    <= 1'b0;
      bus.wbm_sel_o   <= '0;
      bus.wbm_adr_o   <= '0;
      bus.wbm_dat_o   <= '0;
      txn_cnt_o       <= '0;
      err_cnt_o       <= '0;
      stray_ack_o     <= 1'b0;
    end else begin
      // cyc_q is the registered bus cycle, so this sees exactly what the slave saw
      if (bus.wbm_ack_i && !cyc_q) stray_ack_o <= 1'b1;

      unique case (state)
        IDLE: begin
          bus.cmd_ready_o <= 1'b1;
          if (bus.cmd_valid_i && bus.cmd_ready_o) begin
            bus.cmd_ready_o <= 1'b0;
            cyc_q           <= 1'b1;
            bus.wbm_we_o    <= bus.cmd_we_i;
            bus.wbm_sel_o   <= bus.cmd_sel_i;
            bus.wbm_adr_o   <= bus.cmd_adr_i;
            bus.wbm_dat_o   <= bus.cmd_we_i ? bus.cmd_dat_i : 32'h0;
            wait_cnt        <= '0;
            state           <= BUS;
          end
        end
        BUS: begin
          if (bus.wbm_ack_i) begin
            cyc_q           <= 1'b0;
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_dat_o   <= bus.wbm_we_o ? 32'h0 : bus.wbm_dat_i;
            bus.rsp_err_o   <= 1'b0;
            state           <= RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            cyc_q           <= 1'b0;
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_dat_o   <= 32'h0;
            bus.rsp_err_o   <= 1'b1;
            if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
            state           <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            bus.rsp_valid_o <= 1'b0;
            bus.cmd_ready_o <= 1'b1;
            txn_cnt_o       <= txn_cnt_o + 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
